// File: rtl/switch_debouncer_pkg.sv
// Shared constants and types for the switch input conditioning slice.
package switch_debouncer_pkg;

    localparam logic [7:0]  SWITCH_BASE_ADDR        = 8'hD2;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50000;
    localparam int unsigned SWITCH_WIDTH            = 8;

    typedef logic [SWITCH_WIDTH-1:0] switch_word_t;

endpackage

// File: rtl/switch_debouncer_debounce_bit.sv
// One switch bit: two-flop synchroniser, consecutive-mismatch counter,
// accepted stable level and a one-cycle toggle pulse on acceptance.
module debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic sw_raw,
    output logic stable,
    output logic toggle
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 s1;
    logic                 s2;
    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= sw_raw;
            s2 <= s1;
        end
    end

    // Any return to the stable level discards all progress; no partial credit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt    <= '0;
            stable <= 1'b0;
            toggle <= 1'b0;
        end else begin
            toggle <= 1'b0;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= s2;
                cnt    <= '0;
                toggle <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces WIDTH raw switch pins and raises a sticky level interrupt,
// with a per-bit change mask, whenever any debounced bit changes.
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int unsigned WIDTH           = SWITCH_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] SW_RAW,
    output logic [WIDTH-1:0] SWITCH_VALUE,
    output logic [WIDTH-1:0] CHANGE_MASK,
    output logic             BUS_INTERRUPT_RAISE,
    input  logic             BUS_INTERRUPT_ACK
);

    logic [WIDTH-1:0] toggle;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_WIDTH      (CNT_WIDTH)
        ) u_debounce_bit (
            .CLK   (CLK),
            .RST   (RST),
            .sw_raw(SW_RAW[i]),
            .stable(SWITCH_VALUE[i]),
            .toggle(toggle[i])
        );
    end

    // A toggle arriving with ACK starts a fresh event: old mask bits are dropped.
    always_ff @(posedge CLK) begin
        if (RST) begin
            BUS_INTERRUPT_RAISE <= 1'b0;
            CHANGE_MASK         <= '0;
        end else if (|toggle) begin
            BUS_INTERRUPT_RAISE <= 1'b1;
            CHANGE_MASK         <= BUS_INTERRUPT_ACK ? toggle : (CHANGE_MASK | toggle);
        end else if (BUS_INTERRUPT_ACK && BUS_INTERRUPT_RAISE) begin
            BUS_INTERRUPT_RAISE <= 1'b0;
            CHANGE_MASK         <= '0;
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer with DEBOUNCE_CYCLES=4, using a
// sliding-window reference model of the synchronised switch history.
module tb_switch_debouncer;

    localparam int unsigned W = 8;
    localparam int unsigned D = 4;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [W-1:0] SW_RAW = '0;
    logic [W-1:0] SWITCH_VALUE;
    logic [W-1:0] CHANGE_MASK;
    logic         BUS_INTERRUPT_RAISE;
    logic         BUS_INTERRUPT_ACK = 1'b0;

    int unsigned checks = 0;
    int unsigned errors = 0;

    switch_debouncer #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D),
        .CNT_WIDTH      (3)
    ) dut (
        .CLK                (CLK),
        .RST                (RST),
        .SW_RAW             (SW_RAW),
        .SWITCH_VALUE       (SWITCH_VALUE),
        .CHANGE_MASK        (CHANGE_MASK),
        .BUS_INTERRUPT_RAISE(BUS_INTERRUPT_RAISE),
        .BUS_INTERRUPT_ACK  (BUS_INTERRUPT_ACK)
    );

    always #5 CLK = ~CLK;

    // Reference model: a bit flips once the last D synchronised samples all
    // disagree with the accepted level; the interrupt reacts one edge later.
    logic [W-1:0] m_s1 = '0, m_s2 = '0, m_v = '0, m_tog = '0, m_mask = '0;
    logic         m_raise = 1'b0;
    logic [W-1:0] hist[$];

    function automatic void model_edge();
        logic [W-1:0] new_v;
        if (RST) begin
            m_s1 = '0; m_s2 = '0; m_v = '0; m_tog = '0; m_mask = '0; m_raise = 1'b0;
            hist.delete();
        end else begin
            hist.push_back(m_s2);
            if (hist.size() > D) void'(hist.pop_front());
            new_v = m_v;
            if (hist.size() == D) begin
                for (int b = 0; b < W; b++) begin
                    bit all_diff = 1'b1;
                    foreach (hist[i]) if (hist[i][b] == m_v[b]) all_diff = 1'b0;
                    if (all_diff) new_v[b] = ~m_v[b];
                end
            end
            if (m_tog != '0) begin
                m_mask  = BUS_INTERRUPT_ACK ? m_tog : (m_mask | m_tog);
                m_raise = 1'b1;
            end else if (BUS_INTERRUPT_ACK && m_raise) begin
                m_mask  = '0;
                m_raise = 1'b0;
            end
            m_tog = new_v ^ m_v;
            m_v   = new_v;
            m_s2  = m_s1;
            m_s1  = SW_RAW;
        end
    endfunction

    task automatic tick();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        SW_RAW = '0;
        BUS_INTERRUPT_ACK = 1'b0;
        tick(); tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        SW_RAW = 8'($urandom);
        tick(); tick();
        checks++;
        if (SWITCH_VALUE !== 8'h00 || CHANGE_MASK !== 8'h00 || BUS_INTERRUPT_RAISE !== 1'b0) begin
            errors++;
            $display("FAIL reset: value=%h mask=%h raise=%b, expected 00 00 0",
                     SWITCH_VALUE, CHANGE_MASK, BUS_INTERRUPT_RAISE);
        end
        SW_RAW = '0;
        RST = 1'b0;
    endtask

    task automatic test_step_latency();
        do_reset();
        SW_RAW = 8'h01;
        for (int e = 1; e <= 7; e++) begin
            tick();
            checks++;
            if (SWITCH_VALUE !== ((e >= 6) ? 8'h01 : 8'h00)) begin
                errors++;
                $display("FAIL step_value edge %0d: got %h expected %h", e, SWITCH_VALUE,
                         (e >= 6) ? 8'h01 : 8'h00);
            end
            checks++;
            if (BUS_INTERRUPT_RAISE !== (e >= 7) || CHANGE_MASK !== ((e >= 7) ? 8'h01 : 8'h00)) begin
                errors++;
                $display("FAIL step_irq edge %0d: raise=%b mask=%h", e, BUS_INTERRUPT_RAISE, CHANGE_MASK);
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        SW_RAW = 8'h08;
        tick(); tick(); tick();
        SW_RAW = 8'h00;
        for (int e = 0; e < 10; e++) begin
            tick();
            checks++;
            if (SWITCH_VALUE !== 8'h00 || BUS_INTERRUPT_RAISE !== 1'b0) begin
                errors++;
                $display("FAIL glitch cycle %0d: value=%h raise=%b, expected 00 0",
                         e, SWITCH_VALUE, BUS_INTERRUPT_RAISE);
            end
        end
    endtask

    task automatic test_bounce();
        do_reset();
        SW_RAW = 8'h01; tick(); tick();
        SW_RAW = 8'h00; tick();
        SW_RAW = 8'h01;
        for (int e = 1; e <= 7; e++) begin
            tick();
            checks++;
            if (SWITCH_VALUE !== ((e >= 6) ? 8'h01 : 8'h00)) begin
                errors++;
                $display("FAIL bounce edge %0d after last rise: got %h expected %h",
                         e, SWITCH_VALUE, (e >= 6) ? 8'h01 : 8'h00);
            end
        end
    endtask

    task automatic test_ack();
        checks++;
        if (BUS_INTERRUPT_RAISE !== 1'b1 || CHANGE_MASK !== 8'h01) begin
            errors++;
            $display("FAIL ack_pre: raise=%b mask=%h, expected 1 01", BUS_INTERRUPT_RAISE, CHANGE_MASK);
        end
        BUS_INTERRUPT_ACK = 1'b1; tick();
        BUS_INTERRUPT_ACK = 1'b0;
        checks++;
        if (BUS_INTERRUPT_RAISE !== 1'b0 || CHANGE_MASK !== 8'h00) begin
            errors++;
            $display("FAIL ack_clear: raise=%b mask=%h, expected 0 00", BUS_INTERRUPT_RAISE, CHANGE_MASK);
        end
    endtask

    task automatic test_ack_collision();
        test_step_latency();
        SW_RAW = 8'h21;
        for (int e = 0; e < 6; e++) tick();
        BUS_INTERRUPT_ACK = 1'b1; tick();
        BUS_INTERRUPT_ACK = 1'b0;
        checks++;
        if (BUS_INTERRUPT_RAISE !== 1'b1 || CHANGE_MASK !== 8'h20 || SWITCH_VALUE !== 8'h21) begin
            errors++;
            $display("FAIL ack_collision: raise=%b mask=%h value=%h, expected 1 20 21",
                     BUS_INTERRUPT_RAISE, CHANGE_MASK, SWITCH_VALUE);
        end
    endtask

    task automatic test_reset_midcount();
        do_reset();
        SW_RAW = 8'hFF;
        tick(); tick(); tick(); tick();
        RST = 1'b1;
        tick(); tick();
        checks++;
        if (SWITCH_VALUE !== 8'h00 || CHANGE_MASK !== 8'h00 || BUS_INTERRUPT_RAISE !== 1'b0) begin
            errors++;
            $display("FAIL midcount_reset: value=%h mask=%h raise=%b, expected 00 00 0",
                     SWITCH_VALUE, CHANGE_MASK, BUS_INTERRUPT_RAISE);
        end
        RST = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            checks++;
            if (SWITCH_VALUE !== ((e >= 6) ? 8'hFF : 8'h00)) begin
                errors++;
                $display("FAIL midcount_value edge %0d: got %h expected %h", e, SWITCH_VALUE,
                         (e >= 6) ? 8'hFF : 8'h00);
            end
        end
        checks++;
        if (BUS_INTERRUPT_RAISE !== 1'b1 || CHANGE_MASK !== 8'hFF) begin
            errors++;
            $display("FAIL midcount_irq: raise=%b mask=%h, expected 1 ff", BUS_INTERRUPT_RAISE, CHANGE_MASK);
        end
    endtask

    task automatic test_random();
        int unsigned hold [W];
        do_reset();
        for (int b = 0; b < W; b++) hold[b] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < W; b++) begin
                if (hold[b] == 0) begin
                    SW_RAW[b] = 1'($urandom);
                    hold[b]   = $urandom_range(1, 2 * D + 2);
                end else begin
                    hold[b]--;
                end
            end
            BUS_INTERRUPT_ACK = ($urandom_range(0, 7) == 0);
            RST = (c == 300);
            tick();
            checks++;
            if (SWITCH_VALUE !== m_v) begin
                errors++;
                $display("FAIL random_value cycle %0d: got %h expected %h", c, SWITCH_VALUE, m_v);
            end
            checks++;
            if (CHANGE_MASK !== m_mask) begin
                errors++;
                $display("FAIL random_mask cycle %0d: got %h expected %h", c, CHANGE_MASK, m_mask);
            end
            checks++;
            if (BUS_INTERRUPT_RAISE !== m_raise) begin
                errors++;
                $display("FAIL random_raise cycle %0d: got %b expected %b", c, BUS_INTERRUPT_RAISE, m_raise);
            end
        end
        RST = 1'b0;
        BUS_INTERRUPT_ACK = 1'b0;
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_step_latency();
        test_glitch();
        test_bounce();
        tick();
        test_ack();
        test_ack_collision();
        test_reset_midcount();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
